// File: rtl/ps2_control_decoder.sv
// ----------------------------------------------------------------------------
// ps2_control_decoder
//
// Turns the hps_io ps2_key event bus into held button levels for the
// Computer Space controls (left/ccw, right/cw, thrust, fire, start).
// Every press is stretched to at least HOLD_CYCLES clk_sys cycles so that the
// slow game-clock domain always sees short taps. A one-cycle press pulse is
// produced whenever a button's key state rises.
//
// Optional build macro:
//   ALT_KEYS_EN - adds a second physical key per button (A, D, W, left shift,
//                 Enter). The button level is the OR of both key states.
//
// Ports:
//   clk_sys   in   1   system clock, rising edge
//   reset_n   in   1   synchronous active-low reset
//   ps2_key   in  65   [64] toggle, [63:24] extra, [23:16] prev byte,
//                      [15:8] prefix byte, [7:0] scan code
//   clear_all in   1   synchronous clear of key state and hold counters
//   btn       out  5   held levels {start, fire, thrust, right, left}
//   btn_press out  5   one-cycle pulse on each button's key-state rise
// ----------------------------------------------------------------------------
module ps2_control_decoder #(
    parameter int HOLD_CYCLES = 100000,
    parameter int CNT_W       = 17
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [64:0] ps2_key,
    input  logic        clear_all,
    output logic [4:0]  btn,
    output logic [4:0]  btn_press
);

`ifdef ALT_KEYS_EN
    localparam int NK = 10;
`else
    localparam int NK = 5;
`endif

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // One-hot physical-key hit for a 9-bit {ext, scan} code.
    // Keys 0..4 are the base map; keys 5..9 the alternate map.
    function automatic logic [NK-1:0] f_key_hit(input logic [8:0] code9);
        logic [NK-1:0] hit;
        hit = '0;
        case (code9)
            9'h06B, 9'h16B: hit[0] = 1'b1;  // left arrow / keypad 4
            9'h074, 9'h174: hit[1] = 1'b1;  // right arrow / keypad 6
            9'h029:         hit[2] = 1'b1;  // space
            9'h014:         hit[3] = 1'b1;  // left ctrl only
            9'h005:         hit[4] = 1'b1;  // F1
`ifdef ALT_KEYS_EN
            9'h01C:         hit[5] = 1'b1;  // A
            9'h023:         hit[6] = 1'b1;  // D
            9'h01D:         hit[7] = 1'b1;  // W
            9'h012:         hit[8] = 1'b1;  // left shift
            9'h05A:         hit[9] = 1'b1;  // Enter, non-extended
`endif
            default:        hit = '0;
        endcase
        return hit;
    endfunction

    // Button level: OR of every physical key mapped to that button.
    function automatic logic [4:0] f_level(input logic [NK-1:0] ks);
`ifdef ALT_KEYS_EN
        return ks[4:0] | ks[9:5];
`else
        return ks[4:0];
`endif
    endfunction

    logic                    r_toggle;
    logic [NK-1:0]           r_key_state;
    logic [4:0][CNT_W-1:0]   r_cnt;
    logic [4:0]              r_btn;
    logic [4:0]              r_btn_press;

    logic                    w_pressed;
    logic                    w_ext;
    logic                    w_extra_nz;
    logic [8:0]              w_code9;
    logic                    w_event;
    logic [NK-1:0]           w_hit;
    logic [NK-1:0]           w_ks_next;
    logic [4:0]              w_level_cur;
    logic [4:0]              w_level_next;
    logic [4:0]              w_rise;
    logic [4:0][CNT_W-1:0]   w_cnt_next;
    logic [4:0]              w_btn_next;

    // Decode the key bus and compute next key state, counters and outputs.
    always_comb begin
        w_pressed  = (ps2_key[15:8] != 8'hF0);
        // A break carries F0 as prefix, so the E0 marker moves to the previous byte.
        w_ext      = w_pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
        w_extra_nz = (ps2_key[63:24] != 40'd0);
        w_code9    = w_extra_nz ? 9'd0 : {w_ext, ps2_key[7:0]};
        w_event    = (ps2_key[64] != r_toggle) && !w_extra_nz;
        w_hit      = f_key_hit(w_code9);
        w_ks_next  = w_event ? ((r_key_state & ~w_hit) | (w_hit & {NK{w_pressed}}))
                             : r_key_state;

        w_level_cur  = f_level(r_key_state);
        w_level_next = f_level(w_ks_next);
        // A repeat make of a held key leaves the level unchanged, so no reload.
        w_rise       = w_level_next & ~w_level_cur;

        w_cnt_next = '0;
        w_btn_next = 5'd0;
        for (int b = 0; b < 5; b++) begin
            if (w_rise[b]) begin
                w_cnt_next[b] = HOLD_LD;
            end else if (r_cnt[b] != '0) begin
                w_cnt_next[b] = r_cnt[b] - CNT_ONE;
            end else begin
                w_cnt_next[b] = '0;
            end
            w_btn_next[b] = w_level_next[b] | (w_cnt_next[b] != '0);
        end
    end

    // Toggle tracker follows the bus every cycle, including during reset and clear.
    always_ff @(posedge clk_sys) begin
        r_toggle <= ps2_key[64];
    end

    // Key state, hold counters and registered outputs; clear discards any event.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || clear_all) begin
            r_key_state <= '0;
            r_cnt       <= '0;
            r_btn       <= 5'd0;
            r_btn_press <= 5'd0;
        end else begin
            r_key_state <= w_ks_next;
            r_cnt       <= w_cnt_next;
            r_btn       <= w_btn_next;
            r_btn_press <= w_rise;
        end
    end

    assign btn       = r_btn;
    assign btn_press = r_btn_press;

endmodule

// File: tb/tb_ps2_control_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_control_decoder
//
// Scoreboard bench: each driven cycle pushes the expected {btn, btn_press}
// computed by a small behavioural model (absolute hold-end cycle numbers per
// button); the result is popped and compared on the following falling edge.
// Honours ALT_KEYS_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_ps2_control_decoder;

    localparam int HOLD = 50;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [64:0] ps2_key;
    logic        clear_all;
    logic [4:0]  btn;
    logic [4:0]  btn_press;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] exp_q[$];

    // Model state
    logic       m_tq;
    logic [9:0] m_key = 10'd0;
    int         m_hold_end[5] = '{0, 0, 0, 0, 0};
    int         m_cyc = 0;

    ps2_control_decoder #(.HOLD_CYCLES(HOLD), .CNT_W(17)) u_dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .clear_all (clear_all),
        .btn       (btn),
        .btn_press (btn_press)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Physical key index for a {ext, scan} code, -1 if unmapped.
    function automatic int map_key(input logic [8:0] c);
        int idx;
        idx = -1;
        if (c[7:0] == 8'h6B) idx = 0;
        else if (c[7:0] == 8'h74) idx = 1;
        else if (c == 9'h029) idx = 2;
        else if (c == 9'h014) idx = 3;
        else if (c == 9'h005) idx = 4;
`ifdef ALT_KEYS_EN
        else if (c == 9'h01C) idx = 5;
        else if (c == 9'h023) idx = 6;
        else if (c == 9'h01D) idx = 7;
        else if (c == 9'h012) idx = 8;
        else if (c == 9'h05A) idx = 9;
`endif
        return idx;
    endfunction

    function automatic logic [4:0] lvl(input logic [9:0] k);
        return k[4:0] | k[9:5];
    endfunction

    // Advance one clock: model predicts, DUT runs, result is compared.
    task automatic tick();
        logic [4:0] eb, ep, old_l, new_l;
        logic       pressed, ext;
        int         idx;
        logic [9:0] e;
        eb = 5'd0;
        ep = 5'd0;
        if (!reset_n || clear_all) begin
            m_key = 10'd0;
            for (int b = 0; b < 5; b++) m_hold_end[b] = 0;
        end else begin
            pressed = (ps2_key[15:8] != 8'hF0);
            ext     = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
            old_l   = lvl(m_key);
            if (ps2_key[64] != m_tq && ps2_key[63:24] == 40'd0) begin
                idx = map_key({ext, ps2_key[7:0]});
                if (idx >= 0) m_key[idx] = pressed;
            end
            new_l = lvl(m_key);
            for (int b = 0; b < 5; b++) begin
                if (new_l[b] && !old_l[b]) begin
                    m_hold_end[b] = m_cyc + HOLD;
                    ep[b] = 1'b1;
                end
                eb[b] = new_l[b] || (m_cyc + 1 <= m_hold_end[b]);
            end
        end
        m_tq = ps2_key[64];
        m_cyc++;
        exp_q.push_back({eb, ep});
        @(posedge clk_sys);
        @(negedge clk_sys);
        e = exp_q.pop_front();
        check("btn", 32'(btn), 32'(e[9:5]));
        check("btn_press", 32'(btn_press), 32'(e[4:0]));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_key(input logic [39:0] extra, input logic [7:0] prev,
                            input logic [7:0] prefix, input logic [7:0] code);
        ps2_key = {~ps2_key[64], extra, prev, prefix, code};
        tick();
    endtask

    int hl;
    int np;

    initial begin
        // 1: reset with toggle high, no toggling afterwards
        reset_n   = 1'b0;
        clear_all = 1'b0;
        ps2_key   = {1'b1, 64'd0};
        idle(3);
        reset_n = 1'b1;
        idle(10);
        check("idle_btn", 32'(btn), 32'd0);

        // 2: space tap, released after 10 cycles, stretched to HOLD cycles
        hl = 0;
        send_key(40'd0, 8'h00, 8'h00, 8'h29);
        check("space_press", 32'(btn_press), 32'h04);
        if (btn[2]) hl++;
        repeat (9) begin tick(); if (btn[2]) hl++; end
        send_key(40'd0, 8'h00, 8'hF0, 8'h29);
        if (btn[2]) hl++;
        repeat (60) begin tick(); if (btn[2]) hl++; end
        check("hold_len", 32'(hl), 32'(HOLD));

        // 3: right arrow held long, extended break drops one cycle later
        send_key(40'd0, 8'h00, 8'hE0, 8'h74);
        idle(200);
        check("right_held", 32'(btn[1]), 32'd1);
        send_key(40'd0, 8'hE0, 8'hF0, 8'h74);
        check("right_fall", 32'(btn[1]), 32'd0);

        // Keypad-4 left (non-extended) tap
        send_key(40'd0, 8'h00, 8'h00, 8'h6B);
        send_key(40'd0, 8'h00, 8'hF0, 8'h6B);
        idle(HOLD + 2);

        // 4: right ctrl ignored; left ctrl with typematic repeats
        send_key(40'd0, 8'h00, 8'hE0, 8'h14);
        check("rctrl_ign", 32'(btn), 32'd0);
        np = 0;
        send_key(40'd0, 8'h00, 8'h00, 8'h14);
        check("lctrl", 32'(btn[3]), 32'd1);
        if (btn_press[3]) np++;
        repeat (3) begin
            idle(4);
            if (btn_press[3]) np++;
            send_key(40'd0, 8'h00, 8'h00, 8'h14);
            if (btn_press[3]) np++;
        end
        idle(3);
        send_key(40'd0, 8'h00, 8'hF0, 8'h14);
        idle(HOLD);
        check("repeat_pulses", 32'(np), 32'd1);

        // Break for a key never pressed: no effect
        send_key(40'd0, 8'h00, 8'hF0, 8'h05);

        // 5: pause sequence ignored; clear in same cycle as F1 make
        send_key(40'hE1_1477_E1F0, 8'h00, 8'h00, 8'h14);
        check("pause_ign", 32'(btn), 32'd0);
        clear_all = 1'b1;
        send_key(40'd0, 8'h00, 8'h00, 8'h05);
        clear_all = 1'b0;
        idle(3);
        check("clear_wins", 32'(btn[4]), 32'd0);

        // Clear while holding, and reset mid-hold
        send_key(40'd0, 8'h00, 8'h00, 8'h05);
        idle(5);
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        idle(2);
        send_key(40'd0, 8'h00, 8'h00, 8'h29);
        send_key(40'd0, 8'h00, 8'hF0, 8'h29);
        idle(5);
        reset_n = 1'b0;
        tick();
        check("reset_drop", 32'(btn), 32'd0);
        reset_n = 1'b1;
        idle(3);

        // Simultaneous left and right
        send_key(40'd0, 8'h00, 8'hE0, 8'h6B);
        send_key(40'd0, 8'h00, 8'hE0, 8'h74);
        check("both_lr", 32'(btn[1:0]), 32'd3);
        send_key(40'd0, 8'hE0, 8'hF0, 8'h6B);
        send_key(40'd0, 8'hE0, 8'hF0, 8'h74);
        idle(HOLD + 2);

`ifdef ALT_KEYS_EN
        // 6: A + left arrow share one button
        np = 0;
        send_key(40'd0, 8'h00, 8'h00, 8'h1C);
        if (btn_press[0]) np++;
        send_key(40'd0, 8'h00, 8'hE0, 8'h6B);
        if (btn_press[0]) np++;
        send_key(40'd0, 8'h00, 8'hF0, 8'h1C);
        if (btn_press[0]) np++;
        repeat (HOLD + 10) begin tick(); if (btn_press[0]) np++; end
        check("alt_held", 32'(btn[0]), 32'd1);
        send_key(40'd0, 8'hE0, 8'hF0, 8'h6B);
        check("alt_fall", 32'(btn[0]), 32'd0);
        check("alt_pulses", 32'(np), 32'd1);
        send_key(40'd0, 8'h00, 8'h00, 8'h5A);
        send_key(40'd0, 8'h00, 8'hE0, 8'h5A);
        send_key(40'd0, 8'h00, 8'hF0, 8'h5A);
        idle(HOLD + 2);
`else
        // Alternate codes are unmapped in the base build
        send_key(40'd0, 8'h00, 8'h00, 8'h1C);
        check("alt_unmapped", 32'(btn), 32'd0);
        send_key(40'd0, 8'h00, 8'hF0, 8'h1C);
        idle(2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
